cc_screen_compositor: RTL and testbench
=======================================

CC_SCREEN_COMPOSITOR -- requirements
Module: cc_screen_compositor

Interface
REQ-001 SHALL have parameter ROWS, default 8: displayed rows per frame.
REQ-002 SHALL have parameter COLS, default 8: bits per row.
REQ-003 SHALL have parameter WORLD_ROWS, default 16: playfield rows, where WORLD_ROWS >= ROWS.
REQ-004 SHALL have parameter BLINK_TICKS, default 4: frame ticks per blink phase.
REQ-005 SHALL have port CC_SCREEN_COMPOSITOR_CLOCK_50, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-006 SHALL have port CC_SCREEN_COMPOSITOR_RESET_InHigh, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port CC_SCREEN_COMPOSITOR_FRAME_TICK, input, 1 bit: one-cycle frame-update strobe.
REQ-008 SHALL have port CC_SCREEN_COMPOSITOR_BACK, input, WORLD_ROWS*COLS bits: background. Row r is bits [r*COLS +: COLS].
REQ-009 SHALL have port CC_SCREEN_COMPOSITOR_POINT, input, WORLD_ROWS*COLS bits: player/object layer, same row packing as BACK.
REQ-010 SHALL have ports CC_SCREEN_COMPOSITOR_WINSCR and CC_SCREEN_COMPOSITOR_LOSESCR, input, ROWS*COLS bits each: end screens.
REQ-011 SHALL have ports CC_SCREEN_COMPOSITOR_WIN and CC_SCREEN_COMPOSITOR_LOSE, input, 1 bit each: level flags.
REQ-012 SHALL have port CC_SCREEN_COMPOSITOR_SCREEN, output, ROWS*COLS bits: registered frame.
REQ-013 SHALL have port CC_SCREEN_COMPOSITOR_FRAME_VALID, output, 1 bit: pulses when SCREEN updates.
REQ-014 SHALL have port CC_SCREEN_COMPOSITOR_OFFSET, output, $clog2(WORLD_ROWS) bits: current viewport first row.
REQ-015 SHALL have port CC_SCREEN_COMPOSITOR_STATE, output, 2 bits: PLAY=0, WIN=1, LOSE=2.

Function
REQ-016 SHALL act only on FRAME_TICK cycles; between ticks SCREEN, OFFSET and STATE hold and FRAME_VALID=0.
REQ-017 SHALL apply state priority LOSE > WIN > PLAY on every tick; STATE is the state entered on that tick, with no hysteresis.
REQ-018 In PLAY, SHALL set SCREEN row i = BACK row (OFS+i) | POINT row (OFS+i), using the OFS value held before that tick's scroll step.
REQ-019 SHALL compute player row P as the lowest-index POINT row with any bit set.
REQ-020 SHALL compute target T = min((P / ROWS)*ROWS, WORLD_ROWS-ROWS). When POINT is all zero, T = OFS.
REQ-021 SHALL step OFS by exactly ±1 toward T per PLAY tick (smooth scroll); OFS == T means no change.
REQ-022 SHALL guarantee OFS never leaves [0, WORLD_ROWS-ROWS], with no wrap-around.
REQ-023 In WIN/LOSE, SHALL freeze OFS and drive SCREEN from WINSCR/LOSESCR, blink-gated per REQ-030.
REQ-024 SHALL pulse FRAME_VALID high in the cycle after each tick, with latency 1 clock from tick to new SCREEN.
REQ-025 SHALL treat inputs as sampled only on the tick edge; changes between ticks are invisible.

Reset
REQ-026 SHALL, on reset, clear SCREEN=0, FRAME_VALID=0, OFFSET=0, STATE=PLAY, and zero the blink counter/phase at the next edge.
REQ-027 SHALL give reset priority over a coincident FRAME_TICK.
REQ-028 SHALL abandon any scroll in progress on mid-scroll reset, with OFFSET=0 after that edge.

Configuration
REQ-029 SHALL provide macro CC_SCREEN_COMPOSITOR_BLINK_EN.
REQ-030 With CC_SCREEN_COMPOSITOR_BLINK_EN defined:
- In WIN/LOSE, SHALL alternate the end screen (phase 0) and all-zero (phase 1).
- Phase toggles every BLINK_TICKS ticks.
- Counter and phase clear on entry to WIN or LOSE, and on a WIN<->LOSE change.
REQ-031 Without CC_SCREEN_COMPOSITOR_BLINK_EN, SHALL show the end screen steadily, with no blink counter logic.

Structure
REQ-032 SHALL place state encodings (PLAY/WIN/LOSE) and the state typedef in shared package cc_screen_pkg.
REQ-033 SHALL implement REQ-019 in sub-module cc_screen_row_finder: parametrised priority encoder producing P plus a found flag.

Verification
REQ-034 Defaults, POINT bit at row 2, BACK row 0 = 8'hFF, tick -> next cycle FRAME_VALID=1, SCREEN row0=8'hFF, row2 has player bit, OFFSET=0.
REQ-035 Player moved to row 12 from OFS=0 -> OFFSET 1,2,...,8 on 8 successive ticks; each frame shows rows OFS..OFS+7 of the pre-step OFS.
REQ-036 LOSE=1 and WIN=1 together -> STATE=2, SCREEN=LOSESCR, OFFSET frozen; LOSE drops -> STATE=1 on next tick.
REQ-037 BLINK_EN, BLINK_TICKS=4, WIN held -> SCREEN=WINSCR for 4 ticks, 0 for 4 ticks, repeating; without macro, WINSCR on all ticks.
REQ-038 Reset asserted during scroll (OFFSET=5) with a coincident tick -> next edge OFFSET=0, SCREEN=0, FRAME_VALID=0, STATE=0.
REQ-039 WORLD_ROWS=24, ROWS=8, player at row 23 -> scroll stops at OFFSET=16.

Source files
------------

// File: rtl/cc_screen_pkg.sv
// Shared state encoding and state-priority helper for the screen compositor.
package cc_screen_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_WIN  = 2'd1,
    ST_LOSE = 2'd2
  } state_t;

  // LOSE beats WIN beats PLAY, re-evaluated on every frame tick.
  function automatic state_t pick_state(input logic win, input logic lose);
    if (lose) return ST_LOSE;
    if (win)  return ST_WIN;
    return ST_PLAY;
  endfunction

endpackage

// File: rtl/cc_screen_row_finder.sv
// Priority encoder: index of the lowest playfield row with any bit set, plus found flag.
module cc_screen_row_finder
  import cc_screen_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 8,
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [ROWS*COLS-1:0] i_point,
  output logic [RW-1:0]        o_row,
  output logic                 o_found
);

  logic [ROWS-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_hit
      assign w_hit[gi] = |i_point[gi*COLS +: COLS];
    end
  endgenerate

  // Scan from the top down so the lowest hit index is the last one written.
  always_comb begin
    o_row   = '0;
    o_found = 1'b0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        o_row   = RW'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cc_screen_compositor.sv
// Frame compositor: scrolling viewport over BACK|POINT in PLAY, end screens in WIN/LOSE.
// Optional end-screen blinking is enabled by defining CC_SCREEN_COMPOSITOR_BLINK_EN.
module cc_screen_compositor
  import cc_screen_pkg::*;
#(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int WORLD_ROWS  = 16,
  parameter int BLINK_TICKS = 4
) (
  input  logic                          CC_SCREEN_COMPOSITOR_CLOCK_50,
  input  logic                          CC_SCREEN_COMPOSITOR_RESET_InHigh,
  input  logic                          CC_SCREEN_COMPOSITOR_FRAME_TICK,
  input  logic [WORLD_ROWS*COLS-1:0]    CC_SCREEN_COMPOSITOR_BACK,
  input  logic [WORLD_ROWS*COLS-1:0]    CC_SCREEN_COMPOSITOR_POINT,
  input  logic [ROWS*COLS-1:0]          CC_SCREEN_COMPOSITOR_WINSCR,
  input  logic [ROWS*COLS-1:0]          CC_SCREEN_COMPOSITOR_LOSESCR,
  input  logic                          CC_SCREEN_COMPOSITOR_WIN,
  input  logic                          CC_SCREEN_COMPOSITOR_LOSE,
  output logic [ROWS*COLS-1:0]          CC_SCREEN_COMPOSITOR_SCREEN,
  output logic                          CC_SCREEN_COMPOSITOR_FRAME_VALID,
  output logic [$clog2(WORLD_ROWS)-1:0] CC_SCREEN_COMPOSITOR_OFFSET,
  output logic [1:0]                    CC_SCREEN_COMPOSITOR_STATE
);

  localparam int OW      = $clog2(WORLD_ROWS);
  localparam int RW      = (WORLD_ROWS > 1) ? $clog2(WORLD_ROWS) : 1;
  localparam int MAX_OFS = WORLD_ROWS - ROWS;

  state_t               r_state, w_state_next;
  logic [OW-1:0]        r_offset, w_offset_next;
  logic [ROWS*COLS-1:0] r_screen, w_screen_next, w_end_screen;
  logic                 r_valid;
  logic [RW-1:0]        w_p;
  logic                 w_found;
  int                   w_target;

`ifdef CC_SCREEN_COMPOSITOR_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS + 1);
  logic [BW-1:0] r_blink_cnt, w_blink_cnt_next;
  logic          r_phase, w_phase_next;
`endif

  cc_screen_row_finder #(
    .ROWS (WORLD_ROWS),
    .COLS (COLS),
    .RW   (RW)
  ) u_row_finder (
    .i_point (CC_SCREEN_COMPOSITOR_POINT),
    .o_row   (w_p),
    .o_found (w_found)
  );

  always_ff @(posedge CC_SCREEN_COMPOSITOR_CLOCK_50) begin
    if (CC_SCREEN_COMPOSITOR_RESET_InHigh) r_state <= ST_PLAY;
    else                                   r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (CC_SCREEN_COMPOSITOR_FRAME_TICK)
      w_state_next = pick_state(CC_SCREEN_COMPOSITOR_WIN, CC_SCREEN_COMPOSITOR_LOSE);
  end

  // Page-aligned target row, clamped so the viewport never passes the world end.
  always_comb begin
    w_target = int'(r_offset);
    if (w_found) begin
      w_target = (int'(w_p) / ROWS) * ROWS;
      if (w_target > MAX_OFS) w_target = MAX_OFS;
    end
  end

  assign w_end_screen = (w_state_next == ST_LOSE) ? CC_SCREEN_COMPOSITOR_LOSESCR
                                                  : CC_SCREEN_COMPOSITOR_WINSCR;

  always_comb begin
    w_offset_next = r_offset;
    w_screen_next = r_screen;
`ifdef CC_SCREEN_COMPOSITOR_BLINK_EN
    w_blink_cnt_next = r_blink_cnt;
    w_phase_next     = r_phase;
`endif
    if (CC_SCREEN_COMPOSITOR_FRAME_TICK) begin
      case (w_state_next)
        ST_PLAY: begin
          for (int i = 0; i < ROWS; i++) begin
            w_screen_next[i*COLS +: COLS] =
              CC_SCREEN_COMPOSITOR_BACK[(int'(r_offset) + i)*COLS +: COLS] |
              CC_SCREEN_COMPOSITOR_POINT[(int'(r_offset) + i)*COLS +: COLS];
          end
          if (w_target > int'(r_offset))      w_offset_next = r_offset + OW'(1);
          else if (w_target < int'(r_offset)) w_offset_next = r_offset - OW'(1);
`ifdef CC_SCREEN_COMPOSITOR_BLINK_EN
          w_blink_cnt_next = '0;
          w_phase_next     = 1'b0;
`endif
        end
        default: begin
`ifdef CC_SCREEN_COMPOSITOR_BLINK_EN
          // Any change of end state restarts the blink at the visible phase.
          if (w_state_next != r_state) begin
            w_blink_cnt_next = BW'(1);
            w_phase_next     = 1'b0;
          end else if (r_blink_cnt == BW'(BLINK_TICKS)) begin
            w_blink_cnt_next = BW'(1);
            w_phase_next     = ~r_phase;
          end else begin
            w_blink_cnt_next = r_blink_cnt + BW'(1);
          end
          w_screen_next = w_phase_next ? '0 : w_end_screen;
`else
          w_screen_next = w_end_screen;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge CC_SCREEN_COMPOSITOR_CLOCK_50) begin
    if (CC_SCREEN_COMPOSITOR_RESET_InHigh) begin
      r_screen <= '0;
      r_offset <= '0;
      r_valid  <= 1'b0;
`ifdef CC_SCREEN_COMPOSITOR_BLINK_EN
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
`endif
    end else begin
      r_screen <= w_screen_next;
      r_offset <= w_offset_next;
      r_valid  <= CC_SCREEN_COMPOSITOR_FRAME_TICK;
`ifdef CC_SCREEN_COMPOSITOR_BLINK_EN
      r_blink_cnt <= w_blink_cnt_next;
      r_phase     <= w_phase_next;
`endif
    end
  end

  assign CC_SCREEN_COMPOSITOR_SCREEN      = r_screen;
  assign CC_SCREEN_COMPOSITOR_FRAME_VALID = r_valid;
  assign CC_SCREEN_COMPOSITOR_OFFSET      = r_offset;
  assign CC_SCREEN_COMPOSITOR_STATE       = r_state;

endmodule

// File: tb/tb_cc_screen_compositor.sv
// Directed self-checking bench for cc_screen_compositor (default 16-row world plus a 24-row instance).
module tb_cc_screen_compositor;

  logic         clk = 1'b0;
  logic         srst = 1'b1;
  logic         tick = 1'b0;
  logic [127:0] back = '0;
  logic [127:0] point = '0;
  logic [191:0] back24 = '0;
  logic [191:0] point24 = '0;
  logic [63:0]  winscr = 64'hA5A5_5A5A_F00F_0FF0;
  logic [63:0]  losescr = 64'h3C3C_C3C3_1248_8421;
  logic         win = 1'b0;
  logic         lose = 1'b0;

  logic [63:0]  screen, screen24;
  logic         valid, valid24;
  logic [3:0]   offset;
  logic [4:0]   offset24;
  logic [1:0]   state, state24;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cc_screen_compositor dut (
    .CC_SCREEN_COMPOSITOR_CLOCK_50    (clk),
    .CC_SCREEN_COMPOSITOR_RESET_InHigh(srst),
    .CC_SCREEN_COMPOSITOR_FRAME_TICK  (tick),
    .CC_SCREEN_COMPOSITOR_BACK        (back),
    .CC_SCREEN_COMPOSITOR_POINT       (point),
    .CC_SCREEN_COMPOSITOR_WINSCR      (winscr),
    .CC_SCREEN_COMPOSITOR_LOSESCR     (losescr),
    .CC_SCREEN_COMPOSITOR_WIN         (win),
    .CC_SCREEN_COMPOSITOR_LOSE        (lose),
    .CC_SCREEN_COMPOSITOR_SCREEN      (screen),
    .CC_SCREEN_COMPOSITOR_FRAME_VALID (valid),
    .CC_SCREEN_COMPOSITOR_OFFSET      (offset),
    .CC_SCREEN_COMPOSITOR_STATE       (state)
  );

  cc_screen_compositor #(.WORLD_ROWS(24)) dut24 (
    .CC_SCREEN_COMPOSITOR_CLOCK_50    (clk),
    .CC_SCREEN_COMPOSITOR_RESET_InHigh(srst),
    .CC_SCREEN_COMPOSITOR_FRAME_TICK  (tick),
    .CC_SCREEN_COMPOSITOR_BACK        (back24),
    .CC_SCREEN_COMPOSITOR_POINT       (point24),
    .CC_SCREEN_COMPOSITOR_WINSCR      (winscr),
    .CC_SCREEN_COMPOSITOR_LOSESCR     (losescr),
    .CC_SCREEN_COMPOSITOR_WIN         (win),
    .CC_SCREEN_COMPOSITOR_LOSE        (lose),
    .CC_SCREEN_COMPOSITOR_SCREEN      (screen24),
    .CC_SCREEN_COMPOSITOR_FRAME_VALID (valid24),
    .CC_SCREEN_COMPOSITOR_OFFSET      (offset24),
    .CC_SCREEN_COMPOSITOR_STATE       (state24)
  );

  task automatic tick_once;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset;
    srst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (screen !== 64'h0) begin failures++; $display("FAIL reset_screen got=%h exp=0", screen); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (offset !== 4'd0) begin failures++; $display("FAIL reset_offset got=%0d exp=0", offset); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    srst = 1'b0;
    $display("reset: screen=%h valid=%b offset=%0d state=%0d", screen, valid, offset, state);
  endtask

  task automatic test_basic;
    back = '0;
    point = '0;
    back[7:0] = 8'hFF;
    point[2*8 +: 8] = 8'h10;
    tick_once;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", valid); end
    checks++; if (screen[7:0] !== 8'hFF) begin failures++; $display("FAIL basic_row0 got=%h exp=ff", screen[7:0]); end
    checks++; if (screen[23:16] !== 8'h10) begin failures++; $display("FAIL basic_row2 got=%h exp=10", screen[23:16]); end
    checks++; if (screen !== 64'h0000_0000_0010_00FF) begin failures++; $display("FAIL basic_screen got=%h exp=00000000001000ff", screen); end
    checks++; if (offset !== 4'd0) begin failures++; $display("FAIL basic_offset got=%0d exp=0", offset); end
    $display("basic tick: screen=%h valid=%b offset=%0d", screen, valid, offset);
    @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", valid); end
    back = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (screen !== 64'h0000_0000_0010_00FF) begin failures++; $display("FAIL basic_hold got=%h exp=00000000001000ff", screen); end
    $display("between ticks: screen=%h valid=%b", screen, valid);
  endtask

  task automatic test_scroll;
    logic [63:0] exp;
    int r;
    for (int i = 0; i < 16; i++) back[i*8 +: 8] = 8'(i);
    point = '0;
    point[12*8 +: 8] = 8'h80;
    for (int k = 1; k <= 8; k++) begin
      tick_once;
      for (int i = 0; i < 8; i++) begin
        r = k - 1 + i;
        exp[i*8 +: 8] = 8'(r) | ((r == 12) ? 8'h80 : 8'h00);
      end
      checks++; if (offset !== 4'(k)) begin failures++; $display("FAIL scroll_offset k=%0d got=%0d exp=%0d", k, offset, k); end
      checks++; if (screen !== exp) begin failures++; $display("FAIL scroll_screen k=%0d got=%h exp=%h", k, screen, exp); end
      $display("scroll tick %0d: offset=%0d screen=%h", k, offset, screen);
    end
    tick_once;
    checks++; if (offset !== 4'd8) begin failures++; $display("FAIL scroll_settle got=%0d exp=8", offset); end
    $display("scroll settle: offset=%0d", offset);
  endtask

  task automatic test_win_lose;
    point = '0;
    point[7:0] = 8'h01;
    win = 1'b1;
    lose = 1'b1;
    tick_once;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL both_state got=%0d exp=2", state); end
    checks++; if (screen !== losescr) begin failures++; $display("FAIL both_screen got=%h exp=%h", screen, losescr); end
    checks++; if (offset !== 4'd8) begin failures++; $display("FAIL both_offset got=%0d exp=8", offset); end
    $display("win+lose: state=%0d screen=%h offset=%0d", state, screen, offset);
    tick_once;
    checks++; if (offset !== 4'd8) begin failures++; $display("FAIL lose_freeze got=%0d exp=8", offset); end
    lose = 1'b0;
    tick_once;
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL win_state got=%0d exp=1", state); end
    checks++; if (screen !== winscr) begin failures++; $display("FAIL win_screen got=%h exp=%h", screen, winscr); end
    $display("lose dropped: state=%0d screen=%h offset=%0d", state, screen, offset);
    win = 1'b0;
    tick_once;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL play_state got=%0d exp=0", state); end
    checks++; if (offset !== 4'd7) begin failures++; $display("FAIL play_down got=%0d exp=7", offset); end
    $display("back to play: state=%0d offset=%0d", state, offset);
  endtask

  task automatic test_blink;
    logic [63:0] exp;
    win = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick_once;
`ifdef CC_SCREEN_COMPOSITOR_BLINK_EN
      exp = ((((n - 1) / 4) % 2) == 0) ? winscr : 64'h0;
`else
      exp = winscr;
`endif
      checks++; if (screen !== exp) begin failures++; $display("FAIL blink n=%0d got=%h exp=%h", n, screen, exp); end
      $display("win tick %0d: screen=%h", n, screen);
    end
    win = 1'b0;
  endtask

  task automatic test_reset_mid_scroll;
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    point = '0;
    point[12*8 +: 8] = 8'h80;
    repeat (5) tick_once;
    checks++; if (offset !== 4'd5) begin failures++; $display("FAIL midscroll_pre got=%0d exp=5", offset); end
    @(negedge clk);
    srst = 1'b1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    srst = 1'b0;
    checks++; if (offset !== 4'd0) begin failures++; $display("FAIL midscroll_offset got=%0d exp=0", offset); end
    checks++; if (screen !== 64'h0) begin failures++; $display("FAIL midscroll_screen got=%h exp=0", screen); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midscroll_valid got=%b exp=0", valid); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL midscroll_state got=%0d exp=0", state); end
    $display("reset mid-scroll: offset=%0d screen=%h valid=%b state=%0d", offset, screen, valid, state);
  endtask

  task automatic test_world24;
    back24 = '0;
    point24 = '0;
    point24[23*8 +: 8] = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      tick_once;
      if (k == 10) begin
        checks++; if (offset24 !== 5'd10) begin failures++; $display("FAIL w24_mid got=%0d exp=10", offset24); end
      end
      if (k == 16 || k == 20) begin
        checks++; if (offset24 !== 5'd16) begin failures++; $display("FAIL w24_clamp k=%0d got=%0d exp=16", k, offset24); end
      end
      $display("w24 tick %0d: offset=%0d", k, offset24);
    end
    checks++; if (screen24[63:56] !== 8'h01) begin failures++; $display("FAIL w24_row7 got=%h exp=01", screen24[63:56]); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_scroll;
    test_win_lose;
    test_blink;
    test_reset_mid_scroll;
    test_world24;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
